// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port data RAM.
package ram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} ram_state_t;

  localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sweep: walks every address once, then hands the array to the user ports.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned M              = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AddrSz        = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_en,
  output logic [AddrSz-1:0] clr_addr
);

  localparam logic [AddrSz-1:0] LastAddr = AddrSz'(M - 1);
  localparam ram_state_t        RstState = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  ram_state_t        state_q, state_d;
  logic [AddrSz-1:0] cnt_q, cnt_d;
  logic              ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RstState;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LastAddr) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AddrSz'(1);
      end
    end
  end

  // ready is its own flop so it stays low through reset even when the FSM resets into ST_RUN.
  assign ready    = ready_q;
  assign clr_en   = (state_q == ST_INIT);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, optional clear sweep.
module sync_ram_dp
  import ram_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned M              = 32,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AddrSz        = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [AddrSz-1:0] w_addr,
  input  logic [N-1:0]      w_data,
  input  logic              r_en,
  input  logic [AddrSz-1:0] r_addr,
  output logic [N-1:0]      r_data,
  output logic              r_valid,
  output logic              ready
);

  localparam logic [AddrSz:0] AddrLim = (AddrSz + 1)'(M);

  logic [N-1:0]      mem [0:M-1];
  logic              clr_en;
  logic [AddrSz-1:0] clr_addr;
  logic              w_in_range, r_in_range;
  logic              wr_fire, rd_fire;
  logic [N-1:0]      rd_word;
  logic [N-1:0]      r_data_q;
  logic              r_valid_q;

  ram_clear_seq #(
    .M              (M),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign w_in_range = ({1'b0, w_addr} < AddrLim);
  assign r_in_range = ({1'b0, r_addr} < AddrLim);
  assign wr_fire    = ready && w_en && w_in_range;
  assign rd_fire    = ready && r_en;

  // Clear sweep owns the write port while active; user writes are only accepted once ready.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[w_addr] <= w_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      if ((WRITE_FIRST != 0) && wr_fire && (w_addr == r_addr)) begin
        rd_word = w_data;
      end else begin
        rd_word = mem[r_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_fire;
      if (rd_fire) begin
        r_data_q <= rd_word;
      end
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Directed bench: instance A (M=32, read-first, clear on reset), instance B (M=20, write-first, no clear).
module tb_sync_ram_dp;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_w_en = 1'b0, a_r_en = 1'b0;
  logic [4:0] a_w_addr = '0, a_r_addr = '0;
  logic [7:0] a_w_data = '0, a_r_data;
  logic       a_r_valid, a_ready;

  logic       b_w_en = 1'b0, b_r_en = 1'b0;
  logic [4:0] b_w_addr = '0, b_r_addr = '0;
  logic [7:0] b_w_data = '0, b_r_data;
  logic       b_r_valid, b_ready;

  int n_cmp = 0;
  int n_err = 0;

  sync_ram_dp #(.N(8), .M(32), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst),
    .w_en(a_w_en), .w_addr(a_w_addr), .w_data(a_w_data),
    .r_en(a_r_en), .r_addr(a_r_addr),
    .r_data(a_r_data), .r_valid(a_r_valid), .ready(a_ready)
  );

  sync_ram_dp #(.N(8), .M(20), .WRITE_FIRST(1), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst),
    .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .r_en(b_r_en), .r_addr(b_r_addr),
    .r_data(b_r_data), .r_valid(b_r_valid), .ready(b_ready)
  );

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (a_r_data !== 8'h00) begin n_err++; $display("FAIL reset_a_rdata got=%h exp=00", a_r_data); end
    n_cmp++; if (a_r_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_rvalid got=%b exp=0", a_r_valid); end
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
  endtask

  // Runs the 32-edge sweep on A after rst falls; requests injected on edge 5 must be ignored.
  task automatic test_sweep(input bit inject);
    for (int i = 1; i <= 32; i++) begin
      tick();
      n_cmp++; if (a_ready !== (i == 32)) begin n_err++; $display("FAIL sweep_ready edge=%0d got=%b exp=%b", i, a_ready, (i == 32)); end
      if (i < 32) begin
        n_cmp++; if (a_r_valid !== 1'b0) begin n_err++; $display("FAIL sweep_rvalid edge=%0d got=%b exp=0", i, a_r_valid); end
      end
      if (i == 1) begin
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b_ready_first_edge got=%b exp=1", b_ready); end
      end
      if (inject && i == 4) begin
        a_w_en = 1'b1; a_w_addr = 5'd4; a_w_data = 8'hFF; a_r_en = 1'b1; a_r_addr = 5'd4;
      end else begin
        a_w_en = 1'b0; a_r_en = 1'b0;
      end
    end
    n_cmp++; if (a_r_data !== 8'h00) begin n_err++; $display("FAIL sweep_rdata got=%h exp=00", a_r_data); end
  endtask

  task automatic test_read_all_zero();
    for (int i = 0; i < 32; i++) begin
      a_r_en = 1'b1; a_r_addr = 5'(i);
      repeat (RD_LATENCY) tick();
      n_cmp++; if (a_r_data !== 8'h00 || a_r_valid !== 1'b1) begin
        n_err++; $display("FAIL clear_read addr=%0d got=%h/%b exp=00/1", i, a_r_data, a_r_valid);
      end
    end
    a_r_en = 1'b0;
  endtask

  task automatic test_basic();
    a_w_en = 1'b1; a_w_addr = 5'd3;  a_w_data = 8'hA5; tick();
    a_w_addr = 5'd31; a_w_data = 8'h5A; tick();
    a_w_en = 1'b0;
    a_r_en = 1'b1; a_r_addr = 5'd3; tick();
    n_cmp++; if (a_r_data !== 8'hA5 || a_r_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd3 got=%h/%b exp=a5/1", a_r_data, a_r_valid); end
    a_r_addr = 5'd31; tick();
    n_cmp++; if (a_r_data !== 8'h5A || a_r_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd31 got=%h/%b exp=5a/1", a_r_data, a_r_valid); end
    a_r_en = 1'b0; tick();
    n_cmp++; if (a_r_valid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid got=%b exp=0", a_r_valid); end
    n_cmp++; if (a_r_data !== 8'h5A) begin n_err++; $display("FAIL idle_hold got=%h exp=5a", a_r_data); end
  endtask

  task automatic test_back_to_back();
    // Independent write and read at different addresses in the same cycle.
    a_w_en = 1'b1; a_w_addr = 5'd10; a_w_data = 8'hC3;
    a_r_en = 1'b1; a_r_addr = 5'd3; tick();
    n_cmp++; if (a_r_data !== 8'hA5 || a_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd3 got=%h/%b exp=a5/1", a_r_data, a_r_valid); end
    a_w_addr = 5'd11; a_w_data = 8'h3C; a_r_addr = 5'd10; tick();
    n_cmp++; if (a_r_data !== 8'hC3 || a_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd10 got=%h/%b exp=c3/1", a_r_data, a_r_valid); end
    a_w_en = 1'b0; a_r_addr = 5'd11; tick();
    n_cmp++; if (a_r_data !== 8'h3C || a_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd11 got=%h/%b exp=3c/1", a_r_data, a_r_valid); end
    a_r_en = 1'b0; tick();
  endtask

  task automatic test_nonpow2();
    for (int i = 0; i < 20; i++) begin
      b_w_en = 1'b1; b_w_addr = 5'(i); b_w_data = 8'(8'h40 + i); tick();
    end
    b_w_addr = 5'd25; b_w_data = 8'h77; tick();
    b_w_en = 1'b0;
    b_r_en = 1'b1; b_r_addr = 5'd1; tick();
    n_cmp++; if (b_r_data !== 8'h41 || b_r_valid !== 1'b1) begin n_err++; $display("FAIL b_rd1 got=%h/%b exp=41/1", b_r_data, b_r_valid); end
    b_r_addr = 5'd25; tick();
    n_cmp++; if (b_r_data !== 8'h00 || b_r_valid !== 1'b1) begin n_err++; $display("FAIL b_rd_oor got=%h/%b exp=00/1", b_r_data, b_r_valid); end
    for (int i = 0; i < 20; i++) begin
      b_r_addr = 5'(i); tick();
      n_cmp++; if (b_r_data !== 8'(8'h40 + i)) begin n_err++; $display("FAIL b_noalias addr=%0d got=%h exp=%h", i, b_r_data, 8'(8'h40 + i)); end
    end
    b_r_en = 1'b0; tick();
  endtask

  task automatic test_collision();
    a_w_en = 1'b1; a_w_addr = 5'd7; a_w_data = 8'h11;
    b_w_en = 1'b1; b_w_addr = 5'd7; b_w_data = 8'h11; tick();
    a_w_data = 8'h22; a_r_en = 1'b1; a_r_addr = 5'd7;
    b_w_data = 8'h22; b_r_en = 1'b1; b_r_addr = 5'd7; tick();
    n_cmp++; if (a_r_data !== 8'h11) begin n_err++; $display("FAIL coll_read_first got=%h exp=11", a_r_data); end
    n_cmp++; if (b_r_data !== 8'h22) begin n_err++; $display("FAIL coll_write_first got=%h exp=22", b_r_data); end
    a_w_en = 1'b0; b_w_en = 1'b0; tick();
    n_cmp++; if (a_r_data !== 8'h22) begin n_err++; $display("FAIL coll_a_after got=%h exp=22", a_r_data); end
    n_cmp++; if (b_r_data !== 8'h22) begin n_err++; $display("FAIL coll_b_after got=%h exp=22", b_r_data); end
    a_r_en = 1'b0; b_r_en = 1'b0; tick();
  endtask

  task automatic test_mid_reset();
    a_w_en = 1'b1; a_w_addr = 5'd9; a_w_data = 8'h3C; tick();
    a_w_en = 1'b0; a_r_en = 1'b1; a_r_addr = 5'd9; tick();
    n_cmp++; if (a_r_data !== 8'h3C || a_r_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_rd9 got=%h/%b exp=3c/1", a_r_data, a_r_valid); end
    a_r_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_r_data !== 8'h00) begin n_err++; $display("FAIL async_rdata got=%h exp=00", a_r_data); end
    n_cmp++; if (a_r_valid !== 1'b0) begin n_err++; $display("FAIL async_rvalid got=%b exp=0", a_r_valid); end
    n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL async_ready got=%b%b exp=00", a_ready, b_ready); end
    #1 rst = 1'b0;
    test_sweep(1'b0);
    a_r_en = 1'b1; a_r_addr = 5'd9; tick();
    n_cmp++; if (a_r_data !== 8'h00 || a_r_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_rd9 got=%h/%b exp=00/1", a_r_data, a_r_valid); end
    a_r_en = 1'b0;
    // B has no clear sweep, so its contents survive the reset pulse.
    b_r_en = 1'b1; b_r_addr = 5'd7; tick();
    n_cmp++; if (b_r_data !== 8'h22 || b_r_valid !== 1'b1) begin n_err++; $display("FAIL b_retain got=%h/%b exp=22/1", b_r_data, b_r_valid); end
    b_r_en = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    tick();
    rst = 1'b0;
    test_sweep(1'b1);
    test_read_all_zero();
    test_basic();
    test_back_to_back();
    test_nonpow2();
    test_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp.md
Name: sync_ram_dp

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one independent read port, both on a single clock.
- Successor to the single-port data RAM used by the processor datapath.
- Adds:
  - separate read and write addresses, so reads and writes can happen in the same cycle;
  - a registered read with a valid flag;
  - a selectable read-during-write collision policy;
  - a hardware clear sequence after reset, so memory contents are defined at start-up.

Parameters:
- N, 8: data word width in bits (N >= 1).
- M, 32: depth in words (M >= 2; need not be a power of two).
- WRITE_FIRST, 0: collision policy when reading and writing the same address in one cycle. 0 = read returns the old data; 1 = read returns the new write data.
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after reset before accepting requests; 0 = accept requests immediately, contents undefined.
- AddrSz (localparam) = $clog2(M).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- w_addr  input  AddrSz  write address.
- w_data  input  N  write data.
- r_en  input  1  read request.
- r_addr  input  AddrSz  read address.
- r_data  output  N  registered read data.
- r_valid  output  1  r_data holds the result of the previous cycle's accepted read.
- ready  output  1  block is accepting requests (not clearing).

Behaviour:
- Reset is asynchronous and active-high (rst=1).
  - r_data=0, r_valid=0, ready=0 immediately.
  - FSM state goes to ST_INIT if CLEAR_ON_RESET=1, otherwise ST_RUN.
  - Clear counter goes to 0.
  - Array contents are not touched by the asynchronous reset itself.
- ready is a registered output, equal to (state==ST_RUN). It is 0 while rst is asserted, and with CLEAR_ON_RESET=0 it is 1 from the first edge after rst deasserts.
- ST_INIT:
  - Each clock writes 0 to the address held in the clear counter, then increments the counter.
  - When the counter reaches M-1, that write completes and the state moves to ST_RUN.
  - Total sweep: exactly M cycles after rst deasserts; ready rises on edge M.
  - w_en and r_en are ignored; r_valid stays 0 and r_data stays 0.
- ST_RUN:
  - Write: if w_en=1 and w_addr<M, mem[w_addr] is updated at the edge.
  - Read: if r_en=1 and r_addr<M, r_data is loaded at the edge and r_valid=1 the following cycle (latency 1).
  - If r_en=0: r_valid=0 next cycle and r_data holds its last value.
- Collision (w_en=1, r_en=1, w_addr==r_addr, both in range):
  - WRITE_FIRST=0: r_data = previous contents.
  - WRITE_FIRST=1: r_data = w_data.
  - The write always lands in memory.
- Out-of-range address (only possible when M is not a power of two):
  - The write is dropped.
  - The read returns r_data=0 with r_valid=1.
- Different addresses in the same cycle are fully independent, with no stall.
- Reset asserted mid-sweep or mid-operation: outputs return to reset values at once. With CLEAR_ON_RESET=1 the sweep restarts from address 0; it does not resume.
- There is no backpressure: ready is advisory to the requester, and requests made while ready=0 are lost.

Decomposition:
- Shared package ram_pkg holds:
  - typedef enum logic {ST_INIT, ST_RUN} ram_state_t;
  - localparam RD_LATENCY = 1.
- One natural sub-module: ram_clear_seq, the clear counter plus FSM. It outputs ready, clr_en and clr_addr. The top level muxes the clear write over the user write port while clr_en=1.
- The storage array and read register stay in sync_ram_dp. The array is declared [0:M-1].

Test Plan:
- Init sweep (N=8, M=32, CLEAR_ON_RESET=1): release rst, then check ready=0 for 32 cycles and ready=1 on edge 32. Then read all 32 addresses -> every r_data=8'h00 with r_valid=1 one cycle after each r_en.
- Basic write/read: write 8'hA5 to address 3 and 8'h5A to address 31; read address 3, then address 31 -> r_data=8'hA5, then 8'h5A on consecutive cycles; r_valid=1 on both.
- Collision: mem[7]=8'h11; same cycle w_en with w_addr=7, w_data=8'h22, plus r_en with r_addr=7 -> r_data=8'h11 when WRITE_FIRST=0, 8'h22 when WRITE_FIRST=1. A following read of address 7 returns 8'h22 in both cases.
- Requests during clear: assert w_en (address 4, 8'hFF) and r_en at cycle 5 of the sweep -> r_valid stays 0. After ready=1, a read of address 4 returns 8'h00.
- Mid-operation reset: write 8'h3C to address 9, pulse rst mid-cycle -> r_data=0, r_valid=0 and ready=0 immediately, without waiting for a clock edge. The 32-cycle sweep reruns, then a read of address 9 returns 8'h00.
- Non-power-of-two depth (M=20, AddrSz=5): write 8'h77 to address 25 -> dropped, with no aliasing onto addresses 0–19. A read of address 25 gives r_data=0, r_valid=1, and the contents of addresses 0–19 are unchanged.
